// File: rtl/fdiv_seq_if.sv
// Operand/result handshake bundle for the sequential FP divider.
// The master drives operands; the slave (the divider) returns the strobed result.
interface fdiv_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic [31:0] y;
    logic        ovf;
    logic        unf;
    logic        dz;

    modport master (
        output in_valid, x1, x2,
        input  in_ready, out_valid, y, ovf, unf, dz
    );
    modport slave (
        input  in_valid, x1, x2,
        output in_ready, out_valid, y, ovf, unf, dz
    );
endinterface

// File: rtl/fdiv_seq.sv
// Sequential single-precision divider y = x1/x2: radix-2 restoring, one quotient bit per cycle.
// Define FDIV_EARLY_SPECIAL_EN to let zero-operand operations skip the iteration.
module fdiv_seq #(
    parameter int QBITS = 26
) (
    input  logic    clk,
    input  logic    rstn,
    fdiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;

    state_t             state, state_nx;
    logic               accept;
    logic [4:0]         cnt;
    logic [24:0]        rem;
    logic [23:0]        m2_r;
    logic [QBITS-1:0]   q;
    logic               sgn, z1, z2;
    logic signed [9:0]  ep;

    // operand unpack; exponent 0 means zero, so the hidden bit is simply e!=0
    logic [7:0]        e1, e2;
    logic [23:0]       m1_in, m2_in;
    logic signed [9:0] ep_in;
    assign e1    = bus.x1[30:23];
    assign e2    = bus.x2[30:23];
    assign m1_in = {(e1 != 8'd0), bus.x1[22:0]};
    assign m2_in = {(e2 != 8'd0), bus.x2[22:0]};
    assign ep_in = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) begin
                accept   = 1'b1;
`ifdef FDIV_EARLY_SPECIAL_EN
                if ((e1 == 8'd0) || (e2 == 8'd0)) state_nx = ROUND;
                else                              state_nx = DIV;
`else
                state_nx = DIV;
`endif
            end
            DIV:     if (cnt == 5'd0) state_nx = ROUND;
            ROUND:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready = (state == IDLE);

    // restoring step: remainder stays below 2*m2, so 25 bits suffice
    logic        ge;
    logic [24:0] rem_sub, rem_nx;
    assign ge      = (rem >= {1'b0, m2_r});
    assign rem_sub = ge ? (rem - {1'b0, m2_r}) : rem;
    assign rem_nx  = rem_sub << 1;

    // normalize on q[QBITS-1], round half-up on guard
    logic [22:0]       mant_raw;
    logic              guard;
    logic signed [9:0] e_pre, e_fin;
    logic [23:0]       mant_sum;
    logic [31:0]       res_y;
    logic              res_ovf, res_unf, res_dz;

    always_comb begin
        if (q[QBITS-1]) begin
            mant_raw = q[QBITS-2:2];
            guard    = q[1];
            e_pre    = ep;
        end else begin
            mant_raw = q[QBITS-3:1];
            guard    = q[0];
            e_pre    = ep - 10'sd1;
        end
        mant_sum = {1'b0, mant_raw} + {23'd0, guard};
        e_fin    = mant_sum[23] ? (e_pre + 10'sd1) : e_pre;

        res_ovf = 1'b0;
        res_unf = 1'b0;
        res_dz  = 1'b0;
        if (z1) begin
            res_y = 32'd0;
        end else if (z2) begin
            res_dz = 1'b1;
            res_y  = {sgn, 8'hFF, 23'd0};
        end else if (e_fin >= 10'sd255) begin
            res_ovf = 1'b1;
            res_y   = {sgn, 8'hFF, 23'd0};
        end else if (e_fin <= 10'sd0) begin
            res_unf = 1'b1;
            res_y   = {sgn, 31'd0};
        end else begin
            res_y = {sgn, e_fin[7:0], mant_sum[22:0]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= 5'd0;
            rem           <= 25'd0;
            m2_r          <= 24'd0;
            q             <= '0;
            sgn           <= 1'b0;
            z1            <= 1'b0;
            z2            <= 1'b0;
            ep            <= 10'sd0;
            bus.out_valid <= 1'b0;
            bus.y         <= 32'd0;
            bus.ovf       <= 1'b0;
            bus.unf       <= 1'b0;
            bus.dz        <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.out_valid <= 1'b0;
            if (accept) begin
                rem     <= {1'b0, m1_in};
                m2_r    <= m2_in;
                q       <= '0;
                cnt     <= 5'(QBITS - 1);
                sgn     <= bus.x1[31] ^ bus.x2[31];
                z1      <= (e1 == 8'd0);
                z2      <= (e2 == 8'd0);
                ep      <= ep_in;
                bus.ovf <= 1'b0;
                bus.unf <= 1'b0;
                bus.dz  <= 1'b0;
            end
            if (state == DIV) begin
                rem <= rem_nx;
                q   <= {q[QBITS-2:0], ge};
                cnt <= cnt - 5'd1;
            end
            if (state == ROUND) begin
                bus.y         <= res_y;
                bus.ovf       <= res_ovf;
                bus.unf       <= res_unf;
                bus.dz        <= res_dz;
                bus.out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: hand-computed quotients, flags, latency, back-to-back and reset abort.
module tb_fdiv_seq;
    logic clk, rstn;
    fdiv_seq_if bus ();

    fdiv_seq dut (.clk(clk), .rstn(rstn), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // edges from the accept edge to the one that raises out_valid
    localparam int LAT_N = 27;
`ifdef FDIV_EARLY_SPECIAL_EN
    localparam int LAT_S = 1;
`else
    localparam int LAT_S = 27;
`endif

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.x1 = a;
        bus.x2 = b;
        bus.in_valid = 1'b1;
        chk({tag, " ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk({tag, " busy"}, {31'd0, bus.in_ready}, 32'd0);
        chk({tag, " flags cleared"}, {29'd0, bus.ovf, bus.unf, bus.dz}, 32'd0);
    endtask

    task automatic wait_result(input string tag, input logic [31:0] ey, input logic [2:0] eflags,
                               input int elat);
        int k, rdy_bad;
        k = 0;
        rdy_bad = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (!bus.out_valid && bus.in_ready) rdy_bad++;
        end
        chk({tag, " latency"}, k, elat);
        chk({tag, " ready low"}, rdy_bad, 0);
        chk({tag, " y"}, bus.y, ey);
        chk({tag, " ovf/unf/dz"}, {29'd0, bus.ovf, bus.unf, bus.dz}, {29'd0, eflags});
    endtask

    task automatic strobe_drop(input string tag, input logic [31:0] ey);
        @(posedge clk);
        #1;
        chk({tag, " strobe 1 cycle"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, " y held"}, bus.y, ey);
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ey, input logic [2:0] eflags, input int elat);
        start_op(tag, a, b);
        wait_result(tag, ey, eflags, elat);
        strobe_drop(tag, ey);
    endtask

    initial begin
        int seen;
        rstn = 1'b0;
        bus.in_valid = 1'b0;
        bus.x1 = 32'd0;
        bus.x2 = 32'd0;
        #3;
        chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst y", bus.y, 32'd0);
        chk("rst flags", {29'd0, bus.ovf, bus.unf, bus.dz}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // flags are {ovf, unf, dz}
        op("6/2",       32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, LAT_N);
        op("1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, LAT_N);
        op("-6/2",      32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, LAT_N);
        op("1/1+ulp",   32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 3'b000, LAT_N);
        op("1/0",       32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, LAT_S);
        op("-1/0",      32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001, LAT_S);
        op("0/5",       32'h00000000, 32'h40A00000, 32'h00000000, 3'b000, LAT_S);
        op("0/0",       32'h00000000, 32'h00000000, 32'h00000000, 3'b000, LAT_S);
        op("ovf",       32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, LAT_N);
        op("max exp",   32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000, LAT_N);
        op("unf",       32'h00800000, 32'h40000000, 32'h00000000, 3'b010, LAT_N);
        op("-unf",      32'h80800000, 32'h40000000, 32'h80000000, 3'b010, LAT_N);
        op("min exp",   32'h01000000, 32'h40000000, 32'h00800000, 3'b000, LAT_N);

        // second pair presented during the out_valid cycle is taken on the edge that ends it
        start_op("b2b a", 32'h40C00000, 32'h40000000);
        wait_result("b2b a", 32'h40400000, 3'b000, LAT_N);
        bus.x1 = 32'h3F800000;
        bus.x2 = 32'h40400000;
        bus.in_valid = 1'b1;
        chk("b2b ready in strobe", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("b2b strobe drop", {31'd0, bus.out_valid}, 32'd0);
        chk("b2b accepted", {31'd0, bus.in_ready}, 32'd0);
        wait_result("b2b b", 32'h3EAAAAAB, 3'b000, LAT_N);
        strobe_drop("b2b b", 32'h3EAAAAAB);

        // reset in the middle of the iteration aborts it
        start_op("abort", 32'h40C00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort y", bus.y, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("abort no strobe", seen, 0);

        op("after abort", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, LAT_N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
